dmem_responder: RTL and testbench

Data-memory responder: the target end of the memory stage's load/store request interface. It accepts one request at a time over a valid/ready handshake. Stores commit byte-enabled and little-endian into an internal array; load data is sign- or zero-extended. The response is returned after a programmable wait-state count, and the memory stage stalls on the response handshake.

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store target with programmable wait states; DMEM_ERR_EN enables fault detection
// Without DMEM_ERR_EN, addresses wrap modulo DEPTH_BYTES and resp_err is tied low.
module dmem_responder #(
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, nextState;
    logic [3:0]  waitCnt, nextWaitCnt;
    logic [7:0]  mem [DEPTH_BYTES];
    logic [AW-1:0] byteIdx [8];
    logic [63:0] rawData, extData, respData;
    logic [3:0]  numBytes;
    logic        accept, fault, respErr;

    assign accept   = (state == IDLE) && req_valid;
    assign numBytes = 4'd1 << req_size;

    // Every lane index wraps naturally in AW bits; faults (when enabled) suppress any wrapped access.
    always_comb begin
        rawData = '0;
        for (int i = 0; i < 8; i++) begin
            byteIdx[i] = req_addr[AW-1:0] + AW'(i);
            rawData[8*i +: 8] = mem[byteIdx[i]];
        end
    end

`ifdef DMEM_ERR_EN
    logic [2:0] alignMask;
    logic       misaligned, outOfRange;
    assign alignMask  = {req_size == 2'd3, req_size >= 2'd2, req_size >= 2'd1};
    assign misaligned = (req_addr[2:0] & alignMask) != 3'd0;
    assign outOfRange = ({1'b0, req_addr} + 65'(numBytes)) > 65'(DEPTH_BYTES);
    assign fault      = misaligned | outOfRange;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        extData = rawData;
        case (req_size)
            2'd0: extData = req_unsigned ? {56'd0, rawData[7:0]}  : {{56{rawData[7]}},  rawData[7:0]};
            2'd1: extData = req_unsigned ? {48'd0, rawData[15:0]} : {{48{rawData[15]}}, rawData[15:0]};
            2'd2: extData = req_unsigned ? {32'd0, rawData[31:0]} : {{32{rawData[31]}}, rawData[31:0]};
            default: extData = rawData;
        endcase
    end

    // Memory is not reset; stores commit only on the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst && accept && req_write && !fault) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < numBytes)
                    mem[byteIdx[i]] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        req_ready   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        nextState = RESP;
                    end else begin
                        nextState   = WAIT;
                        nextWaitCnt = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (waitCnt == 4'd0)
                    nextState = RESP;
                else
                    nextWaitCnt = waitCnt - 4'd1;
            end
            RESP: begin
                if (resp_ready)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            respData <= '0;
            respErr  <= 1'b0;
        end else if (accept) begin
            respErr  <= fault;
            respData <= (req_write || fault) ? 64'd0 : extData;
        end else if (state == RESP && resp_ready) begin
            respData <= '0;
            respErr  <= 1'b0;
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_rdata = respData;
    assign resp_err   = respErr;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2 and LATENCY 0
// Build with DMEM_ERR_EN to exercise the fault path instead of address wrap.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_write, req_unsigned, resp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rdy0, rdy2, vld0, vld2, err0, err2;
    logic [63:0] rd0, rd2;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // sel = 1 targets the LATENCY=2 instance, sel = 0 the LATENCY=0 instance.
    assign req_ready  = sel ? rdy2 : rdy0;
    assign resp_valid = sel ? vld2 : vld0;
    assign resp_rdata = sel ? rd2  : rd0;
    assign resp_err   = sel ? err2 : err0;

    dmem_responder #(.DEPTH_BYTES(4096), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy2),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(vld2),
        .resp_ready(resp_ready & sel), .resp_rdata(rd2), .resp_err(err2));

    dmem_responder #(.DEPTH_BYTES(4096), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(vld0),
        .resp_ready(resp_ready & ~sel), .resp_rdata(rd0), .resp_err(err0));

    task automatic xfer(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input logic u,
                        output logic [63:0] rd, output logic er, output int lat);
        req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL xfer_timeout addr %h resp_valid got %b exp 1", a, resp_valid);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", resp_err); end
    endtask

    task automatic test_double_round_trip();
        logic [63:0] rd; logic er; int lat;
        sel = 1'b1;
        xfer(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, rd, er, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL dbl_store_latency got %0d exp 3", lat); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL dbl_store_rdata got %h exp 0", rd); end
        xfer(1'b0, 64'h10, 64'h0, 2'd3, 1'b0, rd, er, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL dbl_load_latency got %0d exp 3", lat); end
        checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL dbl_load_rdata got %h exp 1122334455667788", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL dbl_load_err got %b exp 0", er); end
        xfer(1'b0, 64'h10, 64'h0, 2'd1, 1'b0, rd, er, lat);
        checks++; if (rd !== 64'h7788) begin errors++; $display("FAIL half_load_rdata got %h exp 7788", rd); end
        xfer(1'b0, 64'h14, 64'h0, 2'd2, 1'b0, rd, er, lat);
        checks++; if (rd !== 64'h11223344) begin errors++; $display("FAIL word_load_rdata got %h exp 11223344", rd); end
    endtask

    task automatic test_byte_ext();
        logic [63:0] rd; logic er; int lat;
        sel = 1'b1;
        xfer(1'b1, 64'h08, 64'h0, 2'd3, 1'b0, rd, er, lat);
        xfer(1'b1, 64'h08, 64'hFFFFFFFFFFFFFF80, 2'd0, 1'b0, rd, er, lat);
        xfer(1'b0, 64'h08, 64'h0, 2'd0, 1'b0, rd, er, lat);
        checks++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL byte_signed got %h exp ffffffffffffff80", rd); end
        xfer(1'b0, 64'h08, 64'h0, 2'd0, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'h80) begin errors++; $display("FAIL byte_unsigned got %h exp 80", rd); end
        xfer(1'b0, 64'h08, 64'h0, 2'd1, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'h80) begin errors++; $display("FAIL byte_store_span got %h exp 80", rd); end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd; logic er; int lat;
        sel = 1'b0;
        xfer(1'b1, 64'h40, 64'h00000000DEADBEEF, 2'd2, 1'b0, rd, er, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL bp_store_latency got %0d exp 1", lat); end
        req_write = 1'b0; req_addr = 64'h40; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_write = 1'b1; req_wdata = 64'h0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b exp 1", i, resp_valid); end
            checks++; if (resp_rdata !== 64'hFFFFFFFFDEADBEEF) begin errors++; $display("FAIL bp_rdata cycle %0d got %h exp ffffffffdeadbeef", i, resp_rdata); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cycle %0d got %b exp 0", i, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", req_ready); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL bp_release_rdata got %h exp 0", resp_rdata); end
        xfer(1'b0, 64'h40, 64'h0, 2'd2, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'hDEADBEEF) begin errors++; $display("FAIL bp_ignored_store got %h exp deadbeef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat;
        sel = 1'b1;
        xfer(1'b1, 64'h20, 64'h0000000012345678, 2'd2, 1'b0, rd, er, lat);
        req_write = 1'b0; req_addr = 64'h20; req_size = 2'd2; req_unsigned = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_wait_ready got %b exp 0", req_ready); end
        #2 rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", resp_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        xfer(1'b0, 64'h20, 64'h0, 2'd2, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'h12345678) begin errors++; $display("FAIL mid_reload got %h exp 12345678", rd); end
        checks++; if (lat != 3) begin errors++; $display("FAIL mid_reload_latency got %0d exp 3", lat); end
    endtask

`ifdef DMEM_ERR_EN
    task automatic test_faults();
        logic [63:0] rd; logic er; int lat;
        sel = 1'b1;
        xfer(1'b1, 64'h0, 64'h0, 2'd3, 1'b0, rd, er, lat);
        xfer(1'b1, 64'h3, 64'hABCD, 2'd1, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_store_err got %b exp 1", er); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL mis_store_rdata got %h exp 0", rd); end
        checks++; if (lat != 3) begin errors++; $display("FAIL mis_store_latency got %0d exp 3", lat); end
        xfer(1'b0, 64'h3, 64'h0, 2'd0, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'd0 || er !== 1'b0) begin errors++; $display("FAIL mis_byte3 got %h/%b exp 0/0", rd, er); end
        xfer(1'b0, 64'h4, 64'h0, 2'd0, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'd0 || er !== 1'b0) begin errors++; $display("FAIL mis_byte4 got %h/%b exp 0/0", rd, er); end
        xfer(1'b0, 64'hFFC, 64'h0, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL oor_load got %h/%b exp 0/1", rd, er); end
    endtask
`else
    task automatic test_wrap();
        logic [63:0] rd; logic er; int lat;
        logic [7:0] expBytes [4];
        logic [63:0] addrs [4];
        expBytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        addrs    = '{64'hFFE, 64'hFFF, 64'h000, 64'h001};
        sel = 1'b1;
        xfer(1'b1, 64'hFFE, 64'hAABBCCDD, 2'd2, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wrap_store_err got %b exp 0", er); end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, addrs[i], 64'h0, 2'd0, 1'b1, rd, er, lat);
            checks++; if (rd !== {56'd0, expBytes[i]}) begin errors++; $display("FAIL wrap_byte %h got %h exp %h", addrs[i], rd, expBytes[i]); end
        end
        xfer(1'b0, 64'hFFE, 64'h0, 2'd2, 1'b0, rd, er, lat);
        checks++; if (rd !== 64'hFFFFFFFFAABBCCDD) begin errors++; $display("FAIL wrap_word got %h exp ffffffffaabbccdd", rd); end
    endtask
`endif

    initial begin
        rst = 1'b0; sel = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_double_round_trip();
        test_byte_ext();
        test_backpressure();
        test_reset_mid();
`ifdef DMEM_ERR_EN
        test_faults();
`else
        test_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
